// File: rtl/fake_dcache_pkg.sv
// Shared types and helpers for the behavioural data-cache model.
package fake_dcache_pkg;

    localparam int unsigned WORD_W  = 64;
    localparam int unsigned TAG_MAX = 16;
    localparam int unsigned DELAY_W = 8;

    // Galois form of x^16 + x^14 + x^13 + x^11
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef struct packed {
        logic               valid;
        logic [TAG_MAX-1:0] tag;
        logic [WORD_W-1:0]  data;
        logic               err;
        logic [DELAY_W-1:0] delay;
    } mshr_entry_t;

    // Shift the addressed lane down and extend it; doubleword ignores the unsigned bit.
    function automatic logic [WORD_W-1:0] load_extract(input logic [WORD_W-1:0] word,
                                                       input logic [2:0]        addr_lo,
                                                       input logic [2:0]        funct3);
        logic [WORD_W-1:0] sh;
        sh = word >> {addr_lo, 3'b000};
        case (size_e'(funct3[1:0]))
            SZ_B:    return funct3[2] ? {56'b0, sh[7:0]}  : {{56{sh[7]}}, sh[7:0]};
            SZ_H:    return funct3[2] ? {48'b0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
            SZ_W:    return funct3[2] ? {32'b0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
            default: return sh;
        endcase
    endfunction

endpackage

// File: rtl/fake_dcache_lfsr.sv
// 16-bit Galois LFSR that steps only when enabled.
module fake_dcache_lfsr
    import fake_dcache_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [15:0] state
);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SEED;
        end else if (en) begin
            state <= (state >> 1) ^ (state[0] ? LFSR_TAPS : 16'h0000);
        end
    end

endmodule

// File: rtl/fake_dcache_mshr.sv
// Behavioural data cache for LSU bring-up: word array, load MSHR with
// LFSR-jittered latency, registered response stage and flush.
module fake_dcache_mshr
    import fake_dcache_pkg::*;
#(
    parameter int unsigned XLEN        = 64,
    parameter int unsigned ADDR_LEN    = 32,
    parameter int unsigned MEM_DEPTH   = 1024,
    parameter int unsigned MSHR_DEPTH  = 4,
    parameter int unsigned TAG_WIDTH   = 4,
    parameter int unsigned DELAY_BASE  = 3,
    parameter int unsigned JITTER_MASK = 3,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter bit          IN_ORDER    = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 opcode_i,
    input  logic [ADDR_LEN-1:0]  req_addr_i,
    input  logic [2:0]           type_i,
    input  logic [XLEN-1:0]      st_data_i,
    input  logic [TAG_WIDTH-1:0] tag_i,
    input  logic                 flush_i,
    output logic                 resp_valid_o,
    input  logic                 resp_ready_i,
    output logic [XLEN-1:0]      ld_data_o,
    output logic [TAG_WIDTH-1:0] tag_o,
    output logic                 err_o
);

    localparam int unsigned WORD_AW = $clog2(MEM_DEPTH);
    localparam int unsigned IDX_W   = $clog2(MSHR_DEPTH);

    logic [XLEN-1:0]    mem [MEM_DEPTH];
    mshr_entry_t        ent [MSHR_DEPTH];
    logic [IDX_W-1:0]   head, tail;
    logic [15:0]        lfsr;

    size_e              size;
    logic [WORD_AW-1:0] word_idx;
    logic [2:0]         addr_lo;
    logic [5:0]         lane_sh;
    logic               misaligned, out_of_range, acc_err;
    logic [XLEN-1:0]    rd_word, size_mask, st_mask, st_word, ld_word;
    logic [DELAY_W-1:0] new_delay;

    logic               all_valid, rdy_found, sel_found;
    logic [IDX_W-1:0]   free_idx, rdy_idx, sel_idx, alloc_idx;
    logic               accept, ld_accept, st_accept, stage_load;

    // Address decode, store merge and load capture data
    always_comb begin
        size         = size_e'(type_i[1:0]);
        word_idx     = req_addr_i[WORD_AW+2:3];
        addr_lo      = req_addr_i[2:0];
        lane_sh      = {addr_lo, 3'b000};
        out_of_range = |req_addr_i[ADDR_LEN-1:WORD_AW+3];
        case (size)
            SZ_B: begin misaligned = 1'b0;          size_mask = 64'h0000_0000_0000_00FF; end
            SZ_H: begin misaligned = addr_lo[0];    size_mask = 64'h0000_0000_0000_FFFF; end
            SZ_W: begin misaligned = |addr_lo[1:0]; size_mask = 64'h0000_0000_FFFF_FFFF; end
            default: begin misaligned = |addr_lo;   size_mask = 64'hFFFF_FFFF_FFFF_FFFF; end
        endcase
        acc_err   = misaligned | out_of_range;
        rd_word   = mem[word_idx];
        st_mask   = size_mask << lane_sh;
        st_word   = (rd_word & ~st_mask) | ((st_data_i << lane_sh) & st_mask);
        ld_word   = acc_err ? '0 : load_extract(rd_word, addr_lo, type_i);
        new_delay = DELAY_W'(DELAY_BASE) + DELAY_W'(lfsr & 16'(JITTER_MASK));
    end

    // Occupancy, lowest free slot and response source selection
    always_comb begin
        all_valid = 1'b1;
        free_idx  = '0;
        rdy_found = 1'b0;
        rdy_idx   = '0;
        for (int i = MSHR_DEPTH - 1; i >= 0; i--) begin
            all_valid = all_valid & ent[i].valid;
            if (!ent[i].valid) begin
                free_idx = IDX_W'(i);
            end
            if (ent[i].valid && ent[i].delay == '0) begin
                rdy_found = 1'b1;
                rdy_idx   = IDX_W'(i);
            end
        end
        if (IN_ORDER) begin
            sel_idx   = head;
            sel_found = ent[head].valid && ent[head].delay == '0;
            alloc_idx = tail;
        end else begin
            sel_idx   = rdy_idx;
            sel_found = rdy_found;
            alloc_idx = free_idx;
        end
    end

    assign req_ready_o = (~all_valid | opcode_i) & ~rst & ~flush_i;
    assign accept      = req_valid_i & req_ready_o;
    assign ld_accept   = accept & ~opcode_i;
    assign st_accept   = accept & opcode_i & ~acc_err;
    assign stage_load  = sel_found & (~resp_valid_o | resp_ready_i);

    fake_dcache_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .en    (ld_accept),
        .state (lfsr)
    );

    // Backing store; reset reloads the address-derived pattern
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= {32'((i + 1) * 4), 32'(i * 4)};
            end
        end else if (st_accept) begin
            mem[word_idx] <= st_word;
        end
    end

    // MSHR entries, FIFO pointers and the response stage
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            for (int i = 0; i < MSHR_DEPTH; i++) begin
                ent[i] <= '0;
            end
            head         <= '0;
            tail         <= '0;
            resp_valid_o <= 1'b0;
            if (rst) begin
                ld_data_o <= '0;
                tag_o     <= '0;
                err_o     <= 1'b0;
            end
        end else begin
            for (int i = 0; i < MSHR_DEPTH; i++) begin
                if (ent[i].valid && ent[i].delay != '0) begin
                    ent[i].delay <= ent[i].delay - DELAY_W'(1);
                end
            end
            if (stage_load) begin
                ent[sel_idx].valid <= 1'b0;
                resp_valid_o       <= 1'b1;
                ld_data_o          <= ent[sel_idx].data;
                tag_o              <= TAG_WIDTH'(ent[sel_idx].tag);
                err_o              <= ent[sel_idx].err;
                if (IN_ORDER) begin
                    head <= head + IDX_W'(1);
                end
            end else if (resp_ready_i) begin
                resp_valid_o <= 1'b0;
            end
            if (ld_accept) begin
                ent[alloc_idx] <= '{valid: 1'b1, tag: TAG_MAX'(tag_i), data: ld_word,
                                    err: acc_err, delay: new_delay};
                if (IN_ORDER) begin
                    tail <= tail + IDX_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_fake_dcache_mshr.sv
// Bench for fake_dcache_mshr: directed vector table, multi-cycle corner sequences
// and a randomized run against a byte-level memory/queue reference model.
module tb_fake_dcache_mshr;

    logic        clk;
    logic        rst;
    logic        req_valid, opcode, flush, resp_ready;
    logic [31:0] req_addr;
    logic [2:0]  typ;
    logic [63:0] st_data;
    logic [3:0]  tag;

    logic        a_req_ready, a_resp_valid, a_err;
    logic [63:0] a_ld_data;
    logic [3:0]  a_tag;
    logic        b_req_ready, b_resp_valid, b_err;
    logic [63:0] b_ld_data;
    logic [3:0]  b_tag;

    int n_vec = 0;
    int n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // In-order, fixed latency (jitter masked off)
    fake_dcache_mshr #(.DELAY_BASE(3), .JITTER_MASK(0), .IN_ORDER(1'b1)) dut_a (
        .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_ready_o(a_req_ready),
        .opcode_i(opcode), .req_addr_i(req_addr), .type_i(typ), .st_data_i(st_data),
        .tag_i(tag), .flush_i(flush), .resp_valid_o(a_resp_valid), .resp_ready_i(resp_ready),
        .ld_data_o(a_ld_data), .tag_o(a_tag), .err_o(a_err));

    // Out-of-order; seed 4 with mask 4 gives delays 1+4=5 then 1+0=1
    fake_dcache_mshr #(.DELAY_BASE(1), .JITTER_MASK(4), .LFSR_SEED(16'h0004), .IN_ORDER(1'b0)) dut_b (
        .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_ready_o(b_req_ready),
        .opcode_i(opcode), .req_addr_i(req_addr), .type_i(typ), .st_data_i(st_data),
        .tag_i(tag), .flush_i(flush), .resp_valid_o(b_resp_valid), .resp_ready_i(resp_ready),
        .ld_data_o(b_ld_data), .tag_o(b_tag), .err_o(b_err));

    typedef struct packed {
        logic        op;
        logic [31:0] addr;
        logic [2:0]  typ;
        logic [63:0] sd;
        logic [3:0]  tg;
        logic [63:0] exp;
        logic        err;
    } vec_t;

    vec_t        vt[$];
    logic [63:0] mm [1024];
    logic [79:0] expq[$];

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Present one request for one cycle; called at posedge+1, returns at posedge+1
    task automatic issue(input logic op, input logic [31:0] a, input logic [2:0] t,
                         input logic [63:0] d, input logic [3:0] g);
        req_valid = 1'b1; opcode = op; req_addr = a; typ = t; st_data = d; tag = g;
        #1;
        chk("issue_ready", 80'(a_req_ready), 80'(1));
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(output int lat);
        lat = 0;
        while (!a_resp_valid && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    function automatic logic [63:0] ref_load(input logic [63:0] w, input int lo, input int n, input bit uns);
        logic [63:0] v;
        v = '0;
        for (int b = 0; b < n; b++) v[b*8 +: 8] = w[(lo + b)*8 +: 8];
        if (!uns && n < 8 && v[n*8-1]) begin
            for (int b = n * 8; b < 64; b++) v[b] = 1'b1;
        end
        return v;
    endfunction

    task automatic pulse_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int          lat, seen, got;
        logic [63:0] bp_exp [4];
        logic [3:0]  otag [2];
        logic [63:0] odat [2];

        rst = 1'b1; req_valid = 1'b0; opcode = 1'b1; flush = 1'b0; resp_ready = 1'b1;
        req_addr = '0; typ = '0; st_data = '0; tag = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 80'(a_req_ready), 80'(0));
        chk("rst_valid", 80'(a_resp_valid), 80'(0));
        chk("rst_data", 80'(a_ld_data), 80'(0));
        chk("rst_tag", 80'({a_tag, a_err}), 80'(0));
        rst = 1'b0; opcode = 1'b0;
        #1;
        chk("post_rst_ready", 80'(a_req_ready), 80'(1));
        @(posedge clk); #1;

        // Directed table; word i initially holds {(i+1)*4, i*4}
        vt.push_back('{1'b0, 32'h10,   3'd3, 64'h0, 4'd5, 64'h0000000C_00000008, 1'b0});
        vt.push_back('{1'b1, 32'h13,   3'd0, 64'h80, 4'd0, 64'h0, 1'b0});
        vt.push_back('{1'b0, 32'h13,   3'd0, 64'h0, 4'd1, 64'hFFFFFFFF_FFFFFF80, 1'b0});
        vt.push_back('{1'b0, 32'h13,   3'd4, 64'h0, 4'd2, 64'h00000000_00000080, 1'b0});
        vt.push_back('{1'b0, 32'h10,   3'd2, 64'h0, 4'd3, 64'hFFFFFFFF_80000008, 1'b0});
        vt.push_back('{1'b0, 32'h10,   3'd6, 64'h0, 4'd4, 64'h00000000_80000008, 1'b0});
        vt.push_back('{1'b0, 32'h12,   3'd1, 64'h0, 4'd6, 64'hFFFFFFFF_FFFF8000, 1'b0});
        vt.push_back('{1'b1, 32'h1C,   3'd1, 64'h1234BEEF, 4'd0, 64'h0, 1'b0});
        vt.push_back('{1'b0, 32'h1C,   3'd5, 64'h0, 4'd7, 64'h00000000_0000BEEF, 1'b0});
        vt.push_back('{1'b0, 32'h18,   3'd3, 64'h0, 4'd8, 64'h0000BEEF_0000000C, 1'b0});
        vt.push_back('{1'b1, 32'h20,   3'd3, 64'h11223344_55667788, 4'd0, 64'h0, 1'b0});
        vt.push_back('{1'b0, 32'h27,   3'd0, 64'h0, 4'd9, 64'h00000000_00000011, 1'b0});
        vt.push_back('{1'b0, 32'h20,   3'd0, 64'h0, 4'd10, 64'hFFFFFFFF_FFFFFF88, 1'b0});
        vt.push_back('{1'b0, 32'h24,   3'd2, 64'h0, 4'd11, 64'h00000000_11223344, 1'b0});
        vt.push_back('{1'b0, 32'h06,   3'd2, 64'h0, 4'd12, 64'h0, 1'b1});
        vt.push_back('{1'b0, 32'h2000, 3'd3, 64'h0, 4'd13, 64'h0, 1'b1});
        vt.push_back('{1'b1, 32'h06,   3'd2, 64'hDEADBEEF, 4'd0, 64'h0, 1'b0});
        vt.push_back('{1'b1, 32'h2000, 3'd3, 64'hFFFFFFFF_FFFFFFFF, 4'd0, 64'h0, 1'b0});
        vt.push_back('{1'b0, 32'h00,   3'd3, 64'h0, 4'd14, 64'h00000004_00000000, 1'b0});
        vt.push_back('{1'b0, 32'h04,   3'd0, 64'h0, 4'd15, 64'h00000000_00000004, 1'b0});
        vt.push_back('{1'b0, 32'h00,   3'd7, 64'h0, 4'd1, 64'h00000004_00000000, 1'b0});

        foreach (vt[i]) begin
            issue(vt[i].op, vt[i].addr, vt[i].typ, vt[i].sd, vt[i].tg);
            if (!vt[i].op) begin
                wait_resp(lat);
                // eligible DELAY_BASE+1 cycles after accept, then one stage register
                chk($sformatf("v%0d_latency", i), 80'(lat), 80'(4));
                chk($sformatf("v%0d_data", i), 80'(a_ld_data), 80'(vt[i].exp));
                chk($sformatf("v%0d_tag_err", i), 80'({a_tag, a_err}), 80'({vt[i].tg, vt[i].err}));
                @(posedge clk); #1;
            end
        end

        // Fill all four entries under backpressure
        resp_ready = 1'b0;
        bp_exp[0] = 64'h00000024_00000020; bp_exp[1] = 64'h00000028_00000024;
        bp_exp[2] = 64'h0000002C_00000028; bp_exp[3] = 64'h00000030_0000002C;
        for (int k = 0; k < 4; k++) issue(1'b0, 32'h40 + 32'(k * 8), 3'd3, 64'h0, 4'(k));
        req_valid = 1'b1; opcode = 1'b0; req_addr = 32'h60; typ = 3'd3; st_data = 64'hA5A5; tag = 4'd9;
        #1;
        chk("full_load_ready", 80'(a_req_ready), 80'(0));
        opcode = 1'b1;
        #1;
        chk("full_store_ready", 80'(a_req_ready), 80'(1));
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("held_stage", 80'({a_resp_valid, a_tag}), 80'({1'b1, 4'd0}));
        resp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("drain%0d_tag", k), 80'({a_resp_valid, a_tag}), 80'({1'b1, 4'(k)}));
            chk($sformatf("drain%0d_data", k), 80'(a_ld_data), 80'(bp_exp[k]));
            @(posedge clk); #1;
        end
        chk("drain_done", 80'(a_resp_valid), 80'(0));
        issue(1'b0, 32'h60, 3'd3, 64'h0, 4'd6);
        wait_resp(lat);
        chk("store_while_full", 80'(a_ld_data), 80'(64'hA5A5));
        @(posedge clk); #1;

        // Flush with two loads pending; the store in the flush cycle must be dropped
        issue(1'b0, 32'h40, 3'd3, 64'h0, 4'd1);
        issue(1'b0, 32'h48, 3'd3, 64'h0, 4'd2);
        flush = 1'b1; req_valid = 1'b1; opcode = 1'b1; req_addr = 32'h68; typ = 3'd3;
        st_data = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        chk("flush_ready", 80'(a_req_ready), 80'(0));
        @(posedge clk); #1;
        flush = 1'b0; req_valid = 1'b0;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            if (a_resp_valid) seen++;
            @(posedge clk); #1;
        end
        chk("flush_no_resp", 80'(seen), 80'(0));
        issue(1'b0, 32'h68, 3'd3, 64'h0, 4'd7);
        wait_resp(lat);
        chk("post_flush_lat", 80'(lat), 80'(4));
        chk("post_flush_resp", 80'({a_ld_data, a_tag}), 80'({64'h00000038_00000034, 4'd7}));
        @(posedge clk); #1;

        // Reset with a load pending: discarded, memory reloaded
        issue(1'b0, 32'h10, 3'd3, 64'h0, 4'd3);
        pulse_reset();
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            if (a_resp_valid || b_resp_valid) seen++;
            @(posedge clk); #1;
        end
        chk("rst_discard", 80'(seen), 80'(0));
        issue(1'b0, 32'h10, 3'd3, 64'h0, 4'd4);
        wait_resp(lat);
        chk("rst_mem_reload", 80'(a_ld_data), 80'(64'h0000000C_00000008));
        @(posedge clk); #1;

        // Out-of-order return on dut_b
        pulse_reset();
        issue(1'b0, 32'h40, 3'd3, 64'h0, 4'd0);
        issue(1'b0, 32'h48, 3'd3, 64'h0, 4'd1);
        got = 0;
        for (int c = 0; c < 20 && got < 2; c++) begin
            if (b_resp_valid) begin
                otag[got] = b_tag;
                odat[got] = b_ld_data;
                got++;
            end
            @(posedge clk); #1;
        end
        chk("ooo_count", 80'(got), 80'(2));
        chk("ooo_first", 80'({otag[0], odat[0]}), 80'({4'd1, 64'h00000028_00000024}));
        chk("ooo_second", 80'({otag[1], odat[1]}), 80'({4'd0, 64'h00000024_00000020}));

        // Randomized traffic on dut_a against the reference model
        pulse_reset();
        for (int i = 0; i < 1024; i++) mm[i] = {32'((i + 1) * 4), 32'(i * 4)};
        expq.delete();
        for (int cyc = 0; cyc < 900; cyc++) begin
            int  word, sz, n, lo;
            bit  uns, bad;
            logic [63:0] sd;
            if (cyc < 800) begin
                word = $urandom_range(0, 31);
                sz   = $urandom_range(0, 3);
                n    = 1 << sz;
                lo   = $urandom_range(0, 7);
                if ($urandom_range(0, 3) != 0) lo = lo - (lo % n);
                uns  = 1'($urandom_range(0, 1));
                req_valid  = ($urandom_range(0, 9) < 7);
                opcode     = 1'($urandom_range(0, 1));
                req_addr   = 32'(word * 8 + lo);
                if ($urandom_range(0, 15) == 0) req_addr = req_addr | (32'h1 << $urandom_range(13, 31));
                typ        = {uns, 2'(sz)};
                st_data    = {32'($urandom), 32'($urandom)};
                tag        = 4'($urandom);
            end else begin
                req_valid = 1'b0;
                word = 0; sz = 0; n = 1; lo = 0; uns = 1'b0;
            end
            resp_ready = (cyc >= 800) || ($urandom_range(0, 9) < 7);
            @(negedge clk);
            if (req_valid && opcode) chk("rand_store_ready", 80'(a_req_ready), 80'(1));
            if (a_resp_valid && resp_ready) begin
                if (expq.size() == 0) begin
                    chk("rand_unexpected_resp", 80'(1), 80'(0));
                end else begin
                    chk("rand_resp", 80'({a_ld_data, a_tag, a_err}), expq.pop_front());
                end
            end
            if (req_valid && a_req_ready) begin
                bad = ((lo % n) != 0) || (req_addr >= 32'h2000);
                sd  = st_data;
                if (opcode) begin
                    if (!bad) for (int b = 0; b < n; b++) mm[word][(lo + b)*8 +: 8] = sd[b*8 +: 8];
                end else begin
                    expq.push_back(80'({bad ? 64'h0 : ref_load(mm[word], lo, n, uns), tag, bad}));
                end
            end
            @(posedge clk); #1;
        end
        chk("rand_drained", 80'(expq.size()), 80'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
